dvs_event_unpacker: RTL and testbench

Front-end framing stage of the gesture accelerator. It converts the raw byte stream from the UART receiver into single DVS events and drives the accelerator's event valid/ready input.

- Hunts for a sync byte, assembles a fixed 7-byte packet and validates an XOR checksum and the sensor coordinate range.
- Presents each good event through a one-entry output register.
- Counts every discarded packet by cause, so host-side link problems are visible.

---
 rtl/dvs_uart_pkg.sv | 20 ++
 rtl/sat_counter16.sv | 16 +
 rtl/dvs_event_unpacker.sv | 136 +++++++++++++
 tb/tb_dvs_event_unpacker.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvs_uart_pkg.sv
// Shared types and constants for the DVS UART framing stage.
package dvs_uart_pkg;

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    GET_XL = 3'd1,
    GET_YL = 3'd2,
    GET_FL = 3'd3,
    GET_TH = 3'd4,
    GET_TL = 3'd5,
    GET_CK = 3'd6
  } state_t;

  localparam int PKT_LEN = 7;

  localparam int FLAG_X8  = 0;
  localparam int FLAG_Y8  = 1;
  localparam int FLAG_POL = 2;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != 16'hFFFF))
      count <= count + 16'd1;
  end

endmodule

// File: rtl/dvs_event_unpacker.sv
// Frames the UART byte stream into DVS events: sync hunt, 7-byte packet,
// XOR checksum and range check, one-entry output register, discard statistics.
module dvs_event_unpacker
  import dvs_uart_pkg::*;
#(
  parameter int          SENSOR_RES     = 320,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 12000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        event_valid,
  output logic [8:0]  event_x,
  output logic [8:0]  event_y,
  output logic        event_polarity,
  output logic [15:0] event_ts,
  input  logic        event_ready,
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad_chk,
  output logic [15:0] stat_range,
  output logic [15:0] stat_overflow,
  output logic [15:0] stat_timeout,
  output logic [2:0]  debug_state
);

  localparam int     IW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam state_t LAST_STATE = state_t'(PKT_LEN - 1);

  state_t          state, state_next;
  logic [IW-1:0]   idle_cnt;
  logic [7:0]      xl_q, yl_q, th_q, tl_q, chk_acc;
  logic [2:0]      fl_q;
  logic [8:0]      pkt_x, pkt_y;
  logic            timeout_hit, chk_byte, chk_ok, in_range, slot_free;
  logic            load_event, inc_bad, inc_range, inc_ovf;

  assign pkt_x       = {fl_q[FLAG_X8], xl_q};
  assign pkt_y       = {fl_q[FLAG_Y8], yl_q};
  assign chk_byte    = rx_valid && (state == LAST_STATE);
  assign chk_ok      = (chk_acc == rx_data);
  assign in_range    = (int'(pkt_x) < SENSOR_RES) && (int'(pkt_y) < SENSOR_RES);
  assign slot_free   = !event_valid || event_ready;
  // An arriving byte always beats the timeout on the same cycle.
  assign timeout_hit = (state != HUNT) && !rx_valid &&
                       (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

  assign inc_bad    = chk_byte && !chk_ok;
  assign inc_range  = chk_byte && chk_ok && !in_range;
  assign load_event = chk_byte && chk_ok && in_range && slot_free;
  assign inc_ovf    = chk_byte && chk_ok && in_range && !slot_free;

  assign debug_state = state;

  always_ff @(posedge clk) begin
    if (rst)
      state <= HUNT;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout_hit) begin
      state_next = HUNT;
    end else if (rx_valid) begin
      case (state)
        HUNT:    if (rx_data == SYNC_BYTE) state_next = GET_XL;
        GET_XL:  state_next = GET_YL;
        GET_YL:  state_next = GET_FL;
        GET_FL:  state_next = GET_TH;
        GET_TH:  state_next = GET_TL;
        GET_TL:  state_next = GET_CK;
        GET_CK:  state_next = HUNT;
        default: state_next = HUNT;
      endcase
    end
  end

  // Payload shadows; the checksum restarts whenever we sit in HUNT.
  always_ff @(posedge clk) begin
    if (rst) begin
      xl_q    <= '0;
      yl_q    <= '0;
      fl_q    <= '0;
      th_q    <= '0;
      tl_q    <= '0;
      chk_acc <= '0;
    end else if (rx_valid) begin
      case (state)
        HUNT:   chk_acc <= '0;
        GET_XL: begin xl_q <= rx_data;      chk_acc <= chk_acc ^ rx_data; end
        GET_YL: begin yl_q <= rx_data;      chk_acc <= chk_acc ^ rx_data; end
        GET_FL: begin fl_q <= rx_data[2:0]; chk_acc <= chk_acc ^ rx_data; end
        GET_TH: begin th_q <= rx_data;      chk_acc <= chk_acc ^ rx_data; end
        GET_TL: begin tl_q <= rx_data;      chk_acc <= chk_acc ^ rx_data; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      idle_cnt <= '0;
    else if (rx_valid || (state == HUNT))
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      event_valid    <= 1'b0;
      event_x        <= '0;
      event_y        <= '0;
      event_polarity <= 1'b0;
      event_ts       <= '0;
    end else if (load_event) begin
      event_valid    <= 1'b1;
      event_x        <= pkt_x;
      event_y        <= pkt_y;
      event_polarity <= fl_q[FLAG_POL];
      event_ts       <= {th_q, tl_q};
    end else if (event_ready) begin
      event_valid    <= 1'b0;
    end
  end

  sat_counter16 u_cnt_good    (.clk(clk), .rst(rst), .inc(load_event),  .count(stat_good));
  sat_counter16 u_cnt_bad_chk (.clk(clk), .rst(rst), .inc(inc_bad),     .count(stat_bad_chk));
  sat_counter16 u_cnt_range   (.clk(clk), .rst(rst), .inc(inc_range),   .count(stat_range));
  sat_counter16 u_cnt_ovf     (.clk(clk), .rst(rst), .inc(inc_ovf),     .count(stat_overflow));
  sat_counter16 u_cnt_timeout (.clk(clk), .rst(rst), .inc(timeout_hit), .count(stat_timeout));

endmodule

// File: tb/tb_dvs_event_unpacker.sv
// Bench for dvs_event_unpacker: directed vector table, corner sequences and
// randomized traffic against a packet-level reference model.
module tb_dvs_event_unpacker;
  import dvs_uart_pkg::PKT_LEN;

  localparam int         RES  = 320;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TO   = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        event_ready = 1'b0;
  logic        event_valid, event_polarity;
  logic [8:0]  event_x, event_y;
  logic [15:0] event_ts, stat_good, stat_bad_chk, stat_range, stat_overflow, stat_timeout;
  logic [2:0]  debug_state;

  int n_compared = 0;
  int n_mismatched = 0;

  dvs_event_unpacker #(.SENSOR_RES(RES), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .event_valid(event_valid), .event_x(event_x), .event_y(event_y),
    .event_polarity(event_polarity), .event_ts(event_ts), .event_ready(event_ready),
    .stat_good(stat_good), .stat_bad_chk(stat_bad_chk), .stat_range(stat_range),
    .stat_overflow(stat_overflow), .stat_timeout(stat_timeout), .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  // Reference model: bytes collected so far, gap since last byte, held event, counters.
  logic [7:0]  m_q[$];
  int          m_idle;
  logic        m_valid, m_pol;
  logic [8:0]  m_x, m_y;
  logic [15:0] m_ts;
  int          m_good, m_bad, m_range, m_ovf, m_to;

  function automatic int sat(int c);
    return (c < 65535) ? c + 1 : c;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_idle = 0;
    m_valid = 0; m_pol = 0; m_x = '0; m_y = '0; m_ts = '0;
    m_good = 0; m_bad = 0; m_range = 0; m_ovf = 0; m_to = 0;
  endtask

  task automatic model_step(bit v, logic [7:0] d, bit r);
    bit         free, loaded;
    int         sz, xi, yi;
    logic [7:0] c;
    free   = !m_valid || r;
    loaded = 0;
    sz     = m_q.size();
    if (sz > 0 && !v && m_idle == TO - 1) begin
      m_q.delete();
      m_to = sat(m_to);
    end
    m_idle = (v || sz == 0) ? 0 : m_idle + 1;
    if (v) begin
      if (sz == 0) begin
        if (d == SYNC) m_q.push_back(d);
      end else begin
        m_q.push_back(d);
        if (m_q.size() == PKT_LEN) begin
          c  = m_q[1] ^ m_q[2] ^ m_q[3] ^ m_q[4] ^ m_q[5];
          xi = m_q[1] + (m_q[3][0] ? 256 : 0);
          yi = m_q[2] + (m_q[3][1] ? 256 : 0);
          if (c != m_q[6]) m_bad = sat(m_bad);
          else if (xi >= RES || yi >= RES) m_range = sat(m_range);
          else if (free) begin
            loaded = 1;
            m_valid = 1; m_x = 9'(xi); m_y = 9'(yi); m_pol = m_q[3][2];
            m_ts = {m_q[4], m_q[5]};
            m_good = sat(m_good);
          end else m_ovf = sat(m_ovf);
          m_q.delete();
        end
      end
    end
    if (!loaded && r) m_valid = 0;
  endtask

  task automatic check_output(string name, logic [95:0] act, logic [95:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_output("model event", 96'({event_valid, event_x, event_y, event_polarity, event_ts}),
                 96'({m_valid, m_x, m_y, m_pol, m_ts}));
    check_output("model stats", 96'({stat_good, stat_bad_chk, stat_range, stat_overflow, stat_timeout}),
                 96'({16'(m_good), 16'(m_bad), 16'(m_range), 16'(m_ovf), 16'(m_to)}));
    check_output("model state", 96'(debug_state), 96'(m_q.size()));
  endtask

  task automatic apply_stimulus(bit v, logic [7:0] d, bit r);
    rx_valid = v; rx_data = d; event_ready = r;
    @(posedge clk);
    model_step(v, d, r);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1; rx_valid = 0; event_ready = 0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 0;
    compare_all();
  endtask

  task automatic check_stats(string name, int g, int b, int rg, int o, int t);
    check_output(name, 96'({stat_good, stat_bad_chk, stat_range, stat_overflow, stat_timeout}),
                 96'({16'(g), 16'(b), 16'(rg), 16'(o), 16'(t)}));
  endtask

  task automatic send_seq(logic [0:9][7:0] bytes, int n, bit r);
    for (int b = 0; b < n; b++) apply_stimulus(1'b1, bytes[b], r);
  endtask

  function automatic bit rnd_ready(int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  function automatic int rnd_gap();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return 0;
    if (r < 90) return $urandom_range(1, 3);
    if (r < 95) return TO - 1;
    return TO;
  endfunction

  task automatic send_byte(logic [7:0] d, int gap, int pct);
    for (int g = 0; g < gap; g++) apply_stimulus(1'b0, 8'($urandom), rnd_ready(pct));
    apply_stimulus(1'b1, d, rnd_ready(pct));
  endtask

  task automatic send_random_packet();
    int         kind, nsend, pct;
    logic [7:0] p[7];
    logic [8:0] xv, yv;
    logic [4:0] hi;
    logic       pol;
    kind = $urandom_range(0, 9);
    pct  = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 40 : 100);
    xv = 9'($urandom_range(0, RES - 1));
    yv = 9'($urandom_range(0, RES - 1));
    if ($urandom_range(0, 7) == 0) xv = 9'(RES - 1);
    if ($urandom_range(0, 7) == 0) yv = 9'(RES - 1);
    if (kind == 7) begin
      if ($urandom_range(0, 1) == 0) xv = 9'($urandom_range(RES, 511));
      else yv = 9'($urandom_range(RES, 511));
    end
    pol = 1'($urandom_range(0, 1));
    hi  = 5'($urandom_range(0, 31));
    p[0] = SYNC; p[1] = xv[7:0]; p[2] = yv[7:0];
    p[3] = {hi, pol, yv[8], xv[8]};
    p[4] = 8'($urandom); p[5] = 8'($urandom);
    if ($urandom_range(0, 9) == 0) p[4] = SYNC;
    p[6] = p[1] ^ p[2] ^ p[3] ^ p[4] ^ p[5];
    if (kind == 6) p[6] = p[6] ^ 8'(1 << $urandom_range(0, 7));
    if (kind == 8) begin
      nsend = $urandom_range(1, 4);
      for (int i = 0; i < nsend; i++) send_byte(8'($urandom), rnd_gap(), pct);
    end else begin
      nsend = (kind == 9) ? $urandom_range(1, 6) : PKT_LEN;
      for (int i = 0; i < nsend; i++) send_byte(p[i], rnd_gap(), pct);
      if (kind == 9)
        for (int g = 0; g < TO + 2; g++) apply_stimulus(1'b0, 8'($urandom), rnd_ready(pct));
    end
  endtask

  typedef struct {
    logic [0:9][7:0] bytes;
    int              n;
    bit              rdy_body, rdy_last;
    bit              e_valid;
    int              e_x, e_y;
    bit              e_pol;
    logic [15:0]     e_ts;
    int              e_good, e_bad, e_range, e_ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{80'hA5643204123474000000, 7, 1, 1, 1, 100, 50, 1, 16'h1234, 1, 0, 0, 0};
    vecs[1] = '{80'hA5643204123475000000, 7, 1, 1, 0, 100, 50, 1, 16'h1234, 1, 1, 0, 0};
    vecs[2] = '{80'h00FFA5052C02BEEF7A00, 9, 1, 1, 1, 5, 300, 0, 16'hBEEF, 2, 1, 0, 0};
    vecs[3] = '{80'hA5400A0100004B000000, 7, 1, 1, 0, 5, 300, 0, 16'hBEEF, 2, 1, 1, 0};
    vecs[4] = '{80'hA5010204001017000000, 7, 0, 0, 1, 1, 2, 1, 16'h0010, 3, 1, 1, 0};
    vecs[5] = '{80'hA5030400A52082000000, 7, 0, 0, 1, 1, 2, 1, 16'h0010, 3, 1, 1, 1};
    vecs[6] = '{80'hA5C83F06A5CD99000000, 7, 0, 1, 1, 200, 319, 1, 16'hA5CD, 4, 1, 1, 1};

    model_reset();
    do_reset();
    check_output("reset event", 96'({event_valid, event_x, event_y, event_polarity, event_ts}), 96'h0);
    check_stats("reset stats", 0, 0, 0, 0, 0);
    check_output("reset state", 96'(debug_state), 96'h0);

    for (int i = 0; i < 7; i++) begin
      repeat (2) apply_stimulus(1'b0, 8'h00, vecs[i].rdy_body);
      for (int b = 0; b < vecs[i].n; b++)
        apply_stimulus(1'b1, vecs[i].bytes[b], (b == vecs[i].n - 1) ? vecs[i].rdy_last : vecs[i].rdy_body);
      check_output($sformatf("vec%0d event", i),
                   96'({event_valid, event_x, event_y, event_polarity, event_ts}),
                   96'({vecs[i].e_valid, 9'(vecs[i].e_x), 9'(vecs[i].e_y), vecs[i].e_pol, vecs[i].e_ts}));
      check_stats($sformatf("vec%0d stats", i), vecs[i].e_good, vecs[i].e_bad, vecs[i].e_range, vecs[i].e_ovf, 0);
      check_output($sformatf("vec%0d state", i), 96'(debug_state), 96'h0);
    end

    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("ready drop", 96'(event_valid), 96'h0);
    apply_stimulus(1'b0, 8'h00, 1'b0);

    // Inter-byte gap of exactly the timeout aborts the packet.
    apply_stimulus(1'b1, 8'hA5, 1'b1);
    apply_stimulus(1'b1, 8'h64, 1'b1);
    repeat (TO - 1) apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("pre-timeout state", 96'(debug_state), 96'h2);
    check_output("pre-timeout count", 96'(stat_timeout), 96'h0);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("timeout state", 96'(debug_state), 96'h0);
    check_stats("timeout stats", 4, 1, 1, 1, 1);
    send_seq(80'hA5643204123474000000, 7, 1'b1);
    check_output("post-timeout event", 96'({event_valid, event_x, event_y, event_polarity, event_ts}),
                 96'({1'b1, 9'd100, 9'd50, 1'b1, 16'h1234}));
    check_stats("post-timeout stats", 5, 1, 1, 1, 1);

    // A byte landing on the would-be timeout cycle wins.
    apply_stimulus(1'b1, 8'hA5, 1'b1);
    apply_stimulus(1'b1, 8'h64, 1'b1);
    repeat (TO - 1) apply_stimulus(1'b0, 8'h00, 1'b1);
    send_seq(80'h32041234740000000000, 5, 1'b1);
    check_stats("byte-wins stats", 6, 1, 1, 1, 1);
    check_output("byte-wins valid", 96'(event_valid), 96'h1);

    // Reset mid-packet, then resync past a garbage byte.
    send_seq(80'hA5643200000000000000, 3, 1'b0);
    do_reset();
    send_seq(80'h00A56432041234740000, 8, 1'b1);
    check_stats("resync stats", 1, 0, 0, 0, 0);
    check_output("resync event", 96'({event_valid, event_x, event_y, event_polarity, event_ts}),
                 96'({1'b1, 9'd100, 9'd50, 1'b1, 16'h1234}));

    do_reset();
    for (int k = 0; k < 300; k++) send_random_packet();
    repeat (3) apply_stimulus(1'b0, 8'h00, 1'b1);
    $display("[TB] random phase model totals: good=%0d bad=%0d range=%0d ovf=%0d timeout=%0d",
             m_good, m_bad, m_range, m_ovf, m_to);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
